// File: rtl/frame_sync.sv
// rtl/frame_sync.sv - 802.15.4 receive frame synchroniser: preamble/SFD hunt, length check, nibble packing
// Bits arrive one per inValid strobe; payload nibbles are written toward the output FIFO.
module frame_sync #(
  parameter int         PREAMBLE_BITS = 32,
  parameter logic [7:0] SFD           = 8'hA7,
  parameter int         MAX_LEN       = 127
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inData,
  input  logic       inValid,
  input  logic       inFifoFull,
  output logic [3:0] outData,
  output logic       outWriteEnable,
  output logic       outSync,
  output logic [6:0] outLength,
  output logic       outFrameDone,
  output logic       outLengthError,
  output logic       outOverflow
);

  localparam logic [1:0] ST_HUNT     = 2'd0;
  localparam logic [1:0] ST_SFD_WAIT = 2'd1;
  localparam logic [1:0] ST_LEN      = 2'd2;
  localparam logic [1:0] ST_PAYLOAD  = 2'd3;

  localparam logic [5:0] PRE_CNT   = 6'(PREAMBLE_BITS);
  localparam logic [7:0] MAX_LEN_8 = 8'(MAX_LEN);

  logic [1:0] r_state;
  logic [5:0] r_zero_cnt;
  logic       r_win_active;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_nib_cnt;
  logic [3:0] r_data;
  logic       r_we;
  logic       r_sync;
  logic [6:0] r_length;
  logic       r_done;
  logic       r_lerr;
  logic       r_ovf;

  // Right shift with MSB insertion: after N bits the first bit sits at position 8-N.
  logic [7:0] w_shift_next;
  logic [6:0] w_len;
  logic       w_len_ok;
  logic [7:0] w_nib_next;
  logic [7:0] w_nib_total;

  assign w_shift_next = {inData, r_shift[7:1]};
  assign w_len        = w_shift_next[6:0];
  assign w_len_ok     = (w_len != 7'd0) && ({1'b0, w_len} <= MAX_LEN_8);
  assign w_nib_next   = r_nib_cnt + 8'd1;
  assign w_nib_total  = {r_length, 1'b0};

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      r_state      <= ST_HUNT;
      r_zero_cnt   <= 6'd0;
      r_win_active <= 1'b0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_nib_cnt    <= 8'd0;
      r_data       <= 4'd0;
      r_we         <= 1'b0;
      r_sync       <= 1'b0;
      r_length     <= 7'd0;
      r_done       <= 1'b0;
      r_lerr       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_lerr <= 1'b0;
      r_ovf  <= 1'b0;
      if (inValid) begin
        case (r_state)
          ST_HUNT: begin
            if (inData) begin
              r_zero_cnt <= 6'd0;
            end else if (r_zero_cnt != PRE_CNT) begin
              r_zero_cnt <= r_zero_cnt + 6'd1;
              if (r_zero_cnt + 6'd1 == PRE_CNT) begin
                r_state      <= ST_SFD_WAIT;
                r_win_active <= 1'b0;
                r_bit_cnt    <= 3'd0;
              end
            end
          end
          ST_SFD_WAIT: begin
            // Leading zeros beyond the preamble are absorbed until the first 1 opens the window.
            if (r_win_active || inData) begin
              r_shift      <= w_shift_next;
              r_win_active <= 1'b1;
              r_bit_cnt    <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_win_active <= 1'b0;
                r_bit_cnt    <= 3'd0;
                if (w_shift_next == SFD) begin
                  r_state <= ST_LEN;
                  r_sync  <= 1'b1;
                end else begin
                  r_state    <= ST_HUNT;
                  r_zero_cnt <= 6'd0;
                end
              end
            end
          end
          ST_LEN: begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= 3'd0;
              if (w_len_ok) begin
                r_length  <= w_len;
                r_nib_cnt <= 8'd0;
                r_state   <= ST_PAYLOAD;
              end else begin
                r_lerr     <= 1'b1;
                r_sync     <= 1'b0;
                r_state    <= ST_HUNT;
                r_zero_cnt <= 6'd0;
              end
            end
          end
          ST_PAYLOAD: begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt[1:0] == 2'd3) begin
              if (inFifoFull) begin
                r_ovf      <= 1'b1;
                r_sync     <= 1'b0;
                r_state    <= ST_HUNT;
                r_zero_cnt <= 6'd0;
                r_bit_cnt  <= 3'd0;
              end else begin
                r_data    <= w_shift_next[7:4];
                r_we      <= 1'b1;
                r_nib_cnt <= w_nib_next;
                if (w_nib_next == w_nib_total) begin
                  r_done     <= 1'b1;
                  r_sync     <= 1'b0;
                  r_state    <= ST_HUNT;
                  r_zero_cnt <= 6'd0;
                  r_bit_cnt  <= 3'd0;
                end
              end
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  assign outData        = r_data;
  assign outWriteEnable = r_we;
  assign outSync        = r_sync;
  assign outLength      = r_length;
  assign outFrameDone   = r_done;
  assign outLengthError = r_lerr;
  assign outOverflow    = r_ovf;

endmodule

// File: tb/tb_frame_sync.sv
// tb/tb_frame_sync.sv - self-checking bench for frame_sync
// Expected nibbles are queued as frames are built and popped on every write strobe.
module tb_frame_sync;

  logic       inClock = 1'b0;
  logic       inReset;
  logic       inData;
  logic       inValid;
  logic       inFifoFull;
  logic [3:0] outData;
  logic       outWriteEnable;
  logic       outSync;
  logic [6:0] outLength;
  logic       outFrameDone;
  logic       outLengthError;
  logic       outOverflow;

  frame_sync dut (
    .inClock(inClock), .inReset(inReset), .inData(inData), .inValid(inValid),
    .inFifoFull(inFifoFull), .outData(outData), .outWriteEnable(outWriteEnable),
    .outSync(outSync), .outLength(outLength), .outFrameDone(outFrameDone),
    .outLengthError(outLengthError), .outOverflow(outOverflow)
  );

  always #5 inClock = ~inClock;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, done_cnt = 0, lerr_cnt = 0, ovf_cnt = 0, sync_rise = 0;
  logic prev_sync = 1'b0;
  bit   gap_mode = 1'b0;
  logic [7:0] pl [0:127];
  logic [4:0] exp_q [$];

  // Scoreboard monitor: {frame_done, nibble} expected on every write strobe.
  always @(negedge inClock) begin
    logic [4:0] e;
    if (inReset) begin
      prev_sync = 1'b0;
    end else begin
      if (outSync && !prev_sync) sync_rise++;
      prev_sync = outSync;
      if (outLengthError) lerr_cnt++;
      if (outOverflow) ovf_cnt++;
      if (outFrameDone) begin
        done_cnt++;
        checks++;
        if (outWriteEnable !== 1'b1 || outSync !== 1'b0) begin
          errors++;
          $display("FAIL done_align: we=%b sync=%b required we=1 sync=0", outWriteEnable, outSync);
        end
      end
      if (outWriteEnable) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: data=%h done=%b required no write", outData, outFrameDone);
        end else begin
          e = exp_q.pop_front();
          if ({outFrameDone, outData} !== e) begin
            errors++;
            $display("FAIL nibble: got done=%b data=%h required done=%b data=%h",
                     outFrameDone, outData, e[4], e[3:0]);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic full);
    @(negedge inClock);
    inData = b;
    inValid = 1'b1;
    inFifoFull = full;
    if (gap_mode && $urandom_range(0, 1) == 1) begin
      @(negedge inClock);
      inValid = 1'b0;
      inData = 1'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic full);
    for (int i = 0; i < 8; i++) send_bit(v[i], full);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge inClock);
      inValid = 1'b0;
      inFifoFull = 1'b0;
    end
  endtask

  task automatic fill_payload(input int n);
    for (int i = 0; i < n; i++) pl[i] = 8'($urandom_range(1, 255));
  endtask

  task automatic send_frame(input int nz, input logic [7:0] lenb, input int nsend,
                            input int nexp, input bit chk_sync, input int full_byte);
    int len;
    logic [7:0] b;
    logic [3:0] nib;
    len = int'(lenb[6:0]);
    for (int k = 0; k < nexp; k++) begin
      b = pl[k / 2];
      nib = (k % 2 == 1) ? b[7:4] : b[3:0];
      exp_q.push_back({(k == 2 * len - 1), nib});
    end
    send_zeros(nz);
    send_byte(8'hA7, 1'b0);
    if (chk_sync) begin
      @(negedge inClock);
      inValid = 1'b0;
      checks++;
      if (outSync !== 1'b1) begin
        errors++;
        $display("FAIL sync_after_sfd: got %b required 1", outSync);
      end
    end
    send_byte(lenb, 1'b0);
    for (int i = 0; i < nsend; i++) send_byte(pl[i], (i == full_byte));
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: %0d nibbles outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    inReset = 1'b1; inValid = 1'b0; inData = 1'b0; inFifoFull = 1'b0;
    repeat (3) @(negedge inClock);
    checks++;
    if ({outData, outWriteEnable, outSync, outLength, outFrameDone, outLengthError, outOverflow} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h we=%b sync=%b len=%0d required all 0",
               outData, outWriteEnable, outSync, outLength);
    end
    inReset = 1'b0;
    idle(2);
  endtask

  task automatic test_nominal();
    int w0, d0, s0;
    w0 = wr_cnt; d0 = done_cnt; s0 = sync_rise;
    pl[0] = 8'h5C; pl[1] = 8'h3E;
    send_frame(32, 8'h02, 2, 4, 1'b1, -1);
    idle(4);
    check_drained("nominal");
    checks++;
    if (wr_cnt - w0 != 4 || done_cnt - d0 != 1 || sync_rise - s0 != 1) begin
      errors++;
      $display("FAIL nominal_counts: writes=%0d done=%0d sync_rises=%0d required 4 1 1",
               wr_cnt - w0, done_cnt - d0, sync_rise - s0);
    end
    checks++;
    if (outLength !== 7'd2 || outSync !== 1'b0 || outData !== 4'h3) begin
      errors++;
      $display("FAIL nominal_state: len=%0d sync=%b data=%h required 2 0 3", outLength, outSync, outData);
    end
  endtask

  task automatic test_gapped();
    int w0;
    w0 = wr_cnt;
    gap_mode = 1'b1;
    fill_payload(3);
    send_frame(32, 8'h03, 3, 6, 1'b0, -1);
    gap_mode = 1'b0;
    idle(4);
    check_drained("gapped");
    checks++;
    if (wr_cnt - w0 != 6 || outLength !== 7'd3) begin
      errors++;
      $display("FAIL gapped_counts: writes=%0d len=%0d required 6 3", wr_cnt - w0, outLength);
    end
  endtask

  task automatic test_short_preamble();
    int w0, s0;
    w0 = wr_cnt; s0 = sync_rise;
    fill_payload(2);
    send_frame(31, 8'h02, 2, 0, 1'b0, -1);
    idle(4);
    checks++;
    if (wr_cnt - w0 != 0 || sync_rise - s0 != 0) begin
      errors++;
      $display("FAIL short_preamble: writes=%0d sync_rises=%0d required 0 0", wr_cnt - w0, sync_rise - s0);
    end
  endtask

  task automatic test_bad_sfd();
    int w0, s0;
    w0 = wr_cnt; s0 = sync_rise;
    send_zeros(32);
    send_byte(8'hA6, 1'b0);
    fill_payload(2);
    send_frame(33, 8'h02, 2, 4, 1'b1, -1);
    idle(4);
    check_drained("bad_sfd");
    checks++;
    if (wr_cnt - w0 != 4 || sync_rise - s0 != 1) begin
      errors++;
      $display("FAIL bad_sfd: writes=%0d sync_rises=%0d required 4 1", wr_cnt - w0, sync_rise - s0);
    end
  endtask

  task automatic test_length_errors();
    logic [7:0] bad [2];
    int w0, l0;
    bad[0] = 8'h00; bad[1] = 8'h80;
    for (int j = 0; j < 2; j++) begin
      l0 = lerr_cnt;
      send_zeros(32);
      send_byte(8'hA7, 1'b0);
      send_byte(bad[j], 1'b0);
      @(negedge inClock);
      inValid = 1'b0;
      checks++;
      if (outLengthError !== 1'b1 || outSync !== 1'b0) begin
        errors++;
        $display("FAIL len_err_%0d: lerr=%b sync=%b required 1 0", j, outLengthError, outSync);
      end
      idle(2);
      checks++;
      if (lerr_cnt - l0 != 1) begin
        errors++;
        $display("FAIL len_err_pulse_%0d: pulses=%0d required 1", j, lerr_cnt - l0);
      end
    end
    w0 = wr_cnt; l0 = lerr_cnt;
    fill_payload(127);
    send_frame(32, 8'h7F, 127, 254, 1'b0, -1);
    idle(4);
    check_drained("max_len");
    checks++;
    if (wr_cnt - w0 != 254 || outLength !== 7'd127 || lerr_cnt != l0) begin
      errors++;
      $display("FAIL max_len: writes=%0d len=%0d lerr=%0d required 254 127 0",
               wr_cnt - w0, outLength, lerr_cnt - l0);
    end
  endtask

  task automatic test_overflow();
    int w0, d0, o0;
    w0 = wr_cnt; d0 = done_cnt; o0 = ovf_cnt;
    fill_payload(4);
    send_frame(32, 8'h04, 4, 2, 1'b1, 1);
    idle(4);
    check_drained("overflow");
    checks++;
    if (wr_cnt - w0 != 2 || ovf_cnt - o0 != 1 || done_cnt - d0 != 0 || outSync !== 1'b0) begin
      errors++;
      $display("FAIL overflow: writes=%0d ovf=%0d done=%0d sync=%b required 2 1 0 0",
               wr_cnt - w0, ovf_cnt - o0, done_cnt - d0, outSync);
    end
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    fill_payload(4);
    send_frame(32, 8'h04, 2, 4, 1'b0, -1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge inClock);
    inValid = 1'b0;
    #2 inReset = 1'b1;
    #1;
    checks++;
    if ({outData, outWriteEnable, outSync, outLength, outFrameDone, outLengthError, outOverflow} !== 16'd0) begin
      errors++;
      $display("FAIL midframe_reset: data=%h we=%b sync=%b len=%0d required all 0",
               outData, outWriteEnable, outSync, outLength);
    end
    check_drained("pre_reset");
    repeat (2) @(negedge inClock);
    inReset = 1'b0;
    w0 = wr_cnt; d0 = done_cnt;
    fill_payload(2);
    send_frame(32, 8'h02, 2, 4, 1'b0, -1);
    fill_payload(3);
    send_frame(32, 8'h03, 3, 6, 1'b0, -1);
    idle(4);
    check_drained("back_to_back");
    checks++;
    if (wr_cnt - w0 != 10 || done_cnt - d0 != 2 || outLength !== 7'd3) begin
      errors++;
      $display("FAIL back_to_back: writes=%0d done=%0d len=%0d required 10 2 3",
               wr_cnt - w0, done_cnt - d0, outLength);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gapped();
    test_short_preamble();
    test_bad_sfd();
    test_length_errors();
    test_overflow();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
